// File: rtl/ds_pkg.sv
// Shared types and tile geometry for the 2x2 max-pool downsample controller.
package ds_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    POOL  = 2'd1,
    DRAIN = 2'd2
  } ds_state_e;

  localparam int TILE_DIM = 3;
  localparam int POOL_DIM = 2;
  localparam int TILE_PIX = 9;
  localparam int POOL_PIX = 4;

  // Flat raster position of tile element [row][col].
  function automatic int tile_pos(input int row, input int col);
    return row * TILE_DIM + col;
  endfunction

endpackage

// File: rtl/downsample_ctrl_max4.sv
// Combinational unsigned maximum of four WIDTH-bit values.
module max4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_max
);

  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_cd;

  assign w_ab  = (i_a > i_b) ? i_a : i_b;
  assign w_cd  = (i_c > i_d) ? i_c : i_d;
  assign o_max = (w_ab > w_cd) ? w_ab : w_cd;

endmodule

// File: rtl/downsample_ctrl.sv
// Buffers one 3x3 conv tile, pools it 2x2/stride-1 in one cycle, drains 4 results.
// Optional tile counter port tile_count is built when DS_CTRL_STATS_EN is defined.
module downsample_ctrl
  import ds_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             abort,
  output logic             busy,
`ifdef DS_CTRL_STATS_EN
  output logic [CNT_W-1:0] tile_count,
`endif
  output ds_state_e        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high and abort is low; ready/valid here depend on registered state only.

  ds_state_e        r_state;
  logic [3:0]       r_idx;
  logic [1:0]       r_oidx;
  logic [WIDTH-1:0] r_tile [TILE_PIX];
  logic [WIDTH-1:0] r_res  [POOL_PIX];
  logic [WIDTH-1:0] w_max  [POOL_PIX];
  logic             w_in_fire;
  logic             w_out_fire;

  assign in_ready   = (r_state == LOAD);
  assign out_valid  = (r_state == DRAIN);
  assign out_last   = (r_state == DRAIN) && (r_oidx == 2'(POOL_PIX - 1));
  assign out_data   = r_res[r_oidx];
  assign busy       = (r_state != LOAD) || (r_idx != 4'd0);
  assign dbg_state  = r_state;
  assign w_in_fire  = in_valid && in_ready && !abort;
  assign w_out_fire = out_valid && out_ready && !abort;

  for (genvar gi = 0; gi < POOL_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < POOL_DIM; gj++) begin : g_col
      max4 #(.WIDTH(WIDTH)) u_max4 (
        .i_a   (r_tile[tile_pos(gi,     gj)]),
        .i_b   (r_tile[tile_pos(gi,     gj + 1)]),
        .i_c   (r_tile[tile_pos(gi + 1, gj)]),
        .i_d   (r_tile[tile_pos(gi + 1, gj + 1)]),
        .o_max (w_max[gi * POOL_DIM + gj])
      );
    end
  end

  // The tile buffer is never reset: every element is rewritten before it is pooled.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TILE_PIX; i++) begin
      if (w_in_fire && (r_idx == 4'(i))) begin
        r_tile[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_idx   <= 4'd0;
      r_oidx  <= 2'd0;
      for (int i = 0; i < POOL_PIX; i++) begin
        r_res[i] <= '0;
      end
    end else if (abort) begin
      r_state <= LOAD;
      r_idx   <= 4'd0;
      r_oidx  <= 2'd0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            if (r_idx == 4'(TILE_PIX - 1)) begin
              r_idx   <= 4'd0;
              r_state <= POOL;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        POOL: begin
          for (int i = 0; i < POOL_PIX; i++) begin
            r_res[i] <= w_max[i];
          end
          r_oidx  <= 2'd0;
          r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (r_oidx == 2'(POOL_PIX - 1)) begin
              r_oidx  <= 2'd0;
              r_state <= LOAD;
            end else begin
              r_oidx <= r_oidx + 2'd1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef DS_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_count <= '0;
    end else if (w_out_fire && out_last) begin
      tile_count <= tile_count + 1'b1;
    end
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_downsample_ctrl.sv
// Self-checking bench for downsample_ctrl: tile vector table, hand-written corner
// sequences and randomized tiles scored against a max-pool reference model.
module tb_downsample_ctrl;
  import ds_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  typedef logic [WIDTH-1:0] px_t;
  typedef struct {
    px_t px  [9];
    px_t exp [4];
  } vec_t;

  logic      clk;
  logic      rst_n;
  logic      in_valid;
  logic      in_ready;
  px_t       in_data;
  logic      out_valid;
  logic      out_ready;
  px_t       out_data;
  logic      out_last;
  logic      abort;
  logic      busy;
  ds_state_e dbg_state;
`ifdef DS_CTRL_STATS_EN
  logic [CNT_W-1:0] tile_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int pat = 0;
  int exp_tiles = 0;
  logic [WIDTH:0] exp_q[$];
  vec_t vecs [3];

  downsample_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .abort      (abort),
    .busy       (busy),
`ifdef DS_CTRL_STATS_EN
    .tile_count (tile_count),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // reference model: max over each 2x2 window of the 3x3 tile
  function automatic void model_pool(input px_t px [9], output px_t e [4]);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        px_t m = 0;
        for (int di = 0; di < 2; di++) begin
          for (int dj = 0; dj < 2; dj++) begin
            if (px[(i + di) * 3 + j + dj] > m) m = px[(i + di) * 3 + j + dj];
          end
        end
        e[i * 2 + j] = m;
      end
    end
  endfunction

  task automatic push_exp(input px_t e [4]);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), e[k]});
  endtask

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = 1'b1;
      2: begin
        out_ready = (pat == 0) || (pat == 3);
        pat = (pat + 1) % 4;
      end
      3: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // scoreboard / protocol monitor
  logic prev_stall = 1'b0;
  px_t  prev_data  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_tiles  = 0;
    end else begin
      if (out_valid) check("in_ready_low_while_draining", in_ready, 0);
      if (prev_stall && out_valid) check("out_data_stable_stalled", out_data, prev_data);
`ifdef DS_CTRL_STATS_EN
      begin
        logic [31:0] et;
        et = exp_tiles;
        check("tile_count", tile_count, et[CNT_W-1:0]);
      end
`endif
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          check("out_data", out_data, e[WIDTH-1:0]);
          check("out_last", out_last, e[WIDTH]);
          if (e[WIDTH]) exp_tiles++;
        end
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = out_data;
    end
  end

  // driver tasks
  task automatic send_pixel(input px_t d, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!got) fail_now("input_accept_timeout");
    else acc = cyc;
  endtask

  task automatic send_tile(input px_t px [9], input int max_gap, output int first_acc);
    int acc;
    int g;
    first_acc = -1;
    for (int i = 0; i < 9; i++) begin
      send_pixel(px[i], acc);
      if (i == 0) first_acc = acc;
      if (max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        repeat (g) @(posedge clk);
        if (g > 0) #1;
      end
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    #1;
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
    if (!out_valid) fail_now("out_valid_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int f [3];
    int acc;
    px_t px [9];
    px_t e [4];

    vecs[0].px  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    vecs[0].exp = '{8'd3, 8'd2, 8'd3, 8'd3};
    vecs[1].px  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[1].exp = '{8'd9, 8'd8, 8'd6, 8'd5};
    vecs[2].px  = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    vecs[2].exp = '{8'd255, 8'd0, 8'd0, 8'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, LOAD);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first tile: latency and values
    ready_mode = 1;
    @(posedge clk); #1;
    push_exp(vecs[0].exp);
    send_tile(vecs[0].px, 0, acc);
    @(negedge clk);
    check("lat_pool_out_valid", out_valid, 0);
    check("lat_pool_busy", busy, 1);
    check("lat_pool_in_ready", in_ready, 0);
    @(negedge clk);
    check("lat_drain_out_valid", out_valid, 1);
    wait_drain();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);

    // same tile under 1-0-0-1 backpressure
    @(posedge clk); #1;
    pat = 0;
    ready_mode = 2;
    push_exp(vecs[0].exp);
    send_tile(vecs[0].px, 0, acc);
    wait_drain();

    // table: back-to-back tiles with out_ready high, period check
    ready_mode = 1;
    @(posedge clk); #1;
    for (int v = 0; v < 3; v++) begin
      push_exp(vecs[v].exp);
      send_tile(vecs[v].px, 0, f[v]);
    end
    wait_drain();
    check("tile_period_1", 32'(f[1] - f[0]), 14);
    check("tile_period_2", 32'(f[2] - f[1]), 14);

    // abort after 5 pixels, with a same-cycle input handshake that must be dropped
    for (int i = 0; i < 5; i++) send_pixel(px_t'($urandom_range(100, 200)), acc);
    @(negedge clk);
    check("pre_abort_busy", busy, 1);
    @(posedge clk); #1;
    abort = 1'b1; in_valid = 1'b1; in_data = 8'd77;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_state", dbg_state, LOAD);
    @(posedge clk); #1;
    push_exp(vecs[2].exp);
    send_tile(vecs[2].px, 0, acc);
    wait_drain();

    // abort during DRAIN beats a same-cycle output handshake
    ready_mode = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_exp(vecs[1].exp);
    send_tile(vecs[1].px, 0, acc);
    wait_valid();
    @(posedge clk); #1;
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("drain_abort_out_valid", out_valid, 0);
    check("drain_abort_in_ready", in_ready, 1);
    check("drain_abort_q_untouched", exp_q.size(), 4);
    exp_q.delete();

    // reset after two outputs of a tile
    @(posedge clk); #1;
    push_exp(vecs[0].exp);
    send_tile(vecs[0].px, 0, acc);
    wait_valid();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_outputs_seen", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    push_exp(vecs[1].exp);
    send_tile(vecs[1].px, 0, acc);
    wait_drain();

    // randomized tiles against the reference model
    ready_mode = 3;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 9; i++) begin
        px[i] = (n % 2 == 0) ? px_t'($urandom_range(0, 255)) : px_t'($urandom_range(0, 3));
      end
      model_pool(px, e);
      push_exp(e);
      send_tile(px, 2, acc);
    end
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
